// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: one-word-per-clock AES key expansion with round-key storage; KEYSCHED_ABORT_EN adds an abort input
module aes_key_schedule_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef KEYSCHED_ABORT_EN
  input  logic                abort,
`endif
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                key_ready,
  output logic                rk_valid,
  output logic [5:0]          rk_idx,
  output logic [31:0]         rk_word,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
    r = gf_mul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction
  state_t      state;
  logic [5:0]  i;
  logic [2:0]  j;
  logic [7:0]  rcon;
  logic [31:0] win [NK];
  logic [31:0] store [NW];
  logic        abort_w;
  logic [31:0] t, sub_in, sw, temp, cur;
  logic [3:0]  r_sel;
  logic [5:0]  base;
`ifdef KEYSCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  // win holds the last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1]
  always_comb begin
    t = win[NK-1];
    sub_in = (j == 3'd0) ? {t[23:0], t[31:24]} : t;
    sw = subword(sub_in);
    temp = (j == 3'd0) ? sw ^ {rcon, 24'h0} : (NK == 8 && j == 3'd4) ? sw : t;
    cur = win[0] ^ ((state == EXPAND) ? temp : 32'h0);
  end
  assign rk_valid = busy;
  assign rk_idx = busy ? i : 6'd0;
  assign rk_word = busy ? cur : 32'h0;
  assign r_sel = (rd_round > 4'(NR)) ? 4'd0 : rd_round;
  assign base = {r_sel, 2'b00};
  assign rd_key = (rd_round > 4'(NR)) ? 128'h0 :
                  {store[base], store[base + 6'd1], store[base + 6'd2], store[base + 6'd3]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i <= 6'd0;
      j <= 3'd0;
      rcon <= 8'h01;
      busy <= 1'b0;
      done <= 1'b0;
      key_ready <= 1'b0;
      for (int k = 0; k < NK; k++) win[k] <= 32'h0;
      for (int k = 0; k < NW; k++) store[k] <= 32'h0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        store[i] <= cur;
        for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
        win[NK-1] <= cur;
        i <= i + 6'd1;
        j <= (j == 3'(NK - 1)) ? 3'd0 : j + 3'd1;
      end
      if (state == EXPAND && j == 3'd0) rcon <= xtime(rcon);
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          key_ready <= 1'b0;
          i <= 6'd0;
          j <= 3'd0;
          rcon <= 8'h01;
          for (int k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end
        LOAD: if (abort_w) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (i == 6'(NK - 1)) state <= EXPAND;
        EXPAND: if (abort_w) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (i == 6'(NW - 1)) begin
          state <= FIN;
          busy <= 1'b0;
          done <= 1'b1;
          key_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
- Sequential AES key expansion for AES-128, AES-192 or AES-256, selected at elaboration time.
- Computes one 32-bit schedule word per clock, using a single shared 4-byte S-box and an iterated Rcon.
- Streams each word out as it is produced and stores all of them, so the cipher datapath can read any round key by round index.
- Sits between the key register and the round pipeline.

Parameters:
- KEY_BITS, 128, key length (128, 192 or 256; any other value is an elaboration error).
- Derived, not overridable: NK = KEY_BITS/32; NR = NK+6; NW = 4*(NR+1), which is 44, 52 or 60.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- key_in  in  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] are w[0]; sampled in the start cycle
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse when the schedule is complete
- key_ready  out  1  stored schedule is valid
- rk_valid  out  1  rk_word/rk_idx valid this cycle
- rk_idx  out  6  index i of the word on rk_word
- rk_word  out  32  w[i]
- rd_round  in  4  round-key select, 0..NR
- rd_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, combinational from storage

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; word storage cleared; Rcon register = 8'h01.
- States:
  - IDLE: start=1 → LOAD. In the same edge: key_in captured, key_ready←0, i←0, Rcon←8'h01.
  - LOAD: emits captured key words w[0..NK-1], one per cycle. After i=NK-1 → EXPAND.
  - EXPAND: emits w[i] for i=NK..NW-1, one per cycle. After i=NW-1 → FIN.
  - FIN: done=1 and key_ready←1 for one cycle → IDLE.
- busy=1 in LOAD and EXPAND only.
- Each emitted word is also written to storage slot i in the same cycle.
- Word rule for i≥NK, with temp = w[i-1]:
  - If i mod NK==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon←xtime(Rcon).
  - Else if NK==8 and i mod NK==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- Rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime = shift left 1, XOR 8'h1B if bit7 was set.
- RotWord = {t[23:0], t[31:24]}. SubWord applies the FIPS-197 S-box to each byte; the S-box is combinational.
- Timing: start accepted at edge 0; rk_valid high from cycle 1 through cycle NW (exactly NW consecutive cycles); done in cycle NW+1.
- rk_idx increments by 1 each rk_valid cycle. It holds 0 when rk_valid=0, and rk_word is 0 then too.
- Boundary cases:
  - start while busy or in FIN: ignored, no effect.
  - key_in changes after the start cycle: no effect.
  - rd_key is only meaningful while key_ready=1. If rd_round > NR, rd_key = 0.
  - rst_n asserted mid-schedule: immediate return to reset values; no done pulse.
  - A new start after done restarts from w[0] and clears key_ready until the next FIN.

Optional Feature:
- KEYSCHED_ABORT_EN defined:
  - Adds input abort (1 bit). abort=1 in LOAD or EXPAND → IDLE on the next edge.
  - rk_valid drops in that cycle; no done; key_ready stays 0.
  - abort and start in the same IDLE cycle: start wins; abort is ignored outside busy.
- KEYSCHED_ABORT_EN undefined: the abort port does not exist and the schedule always runs to completion.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start → w[4]=a0fafe17, w[43]=b6630ca6; rk_valid 44 consecutive cycles; done in cycle 45; rd_round=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → w[6]=fe0c91f7, w[51]=01002202; 52 valid cycles.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → w[8]=9ba35411, w[59]=706c631e; this exercises the i mod 8==4 SubWord path.
- Second start pulse at cycle 10 of a 128-bit run → ignored; stream and done timing unchanged.
- rst_n low at cycle 20 → all outputs 0 asynchronously; a fresh start then produces the correct full schedule; rd_round=11 → rd_key=0.
- With KEYSCHED_ABORT_EN: abort at cycle 15 → busy=0 next cycle, no done, key_ready=0.
